// File: rtl/phase_splitter_pipe.sv
// Complementary-phase generator: each accepted word leaves on the plus path after D cycles.
// The minus path carries NOT(word) or the saturating negation, and leaves after D+S cycles.
module phase_splitter_pipe #(
    parameter int  WIDTH     = 10,
    parameter int  MAX_DELAY = 8,
    parameter int  MAX_SKEW  = 4,
    localparam int DW        = $clog2(MAX_DELAY + 1),
    localparam int SW        = $clog2(MAX_SKEW + 1)
) (
`ifdef USE_POWER_PINS
    inout  wire              vdd,
    inout  wire              vss,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             cfg_load,
    input  logic [DW-1:0]    cfg_delay,
    input  logic [SW-1:0]    cfg_skew,
    input  logic             cfg_mode,
    output logic             plus_valid,
    output logic [WIDTH-1:0] plus_data,
    output logic             minus_valid,
    output logic [WIDTH-1:0] minus_data,
    output logic             busy
);

    localparam int               DEPTH    = MAX_DELAY + MAX_SKEW;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [DW-1:0]    cur_delay;
    logic [SW-1:0]    cur_skew;
    logic             cur_mode;
    logic [DW-1:0]    new_delay;
    logic [SW-1:0]    new_skew;
    logic [WIDTH-1:0] neg_word;

    logic [DEPTH-1:0] pipe_v;
    logic [WIDTH-1:0] pipe_p [DEPTH];
    logic [WIDTH-1:0] pipe_m [DEPTH];

    int               tap_p;
    int               tap_m;
    logic             tap_p_v;
    logic             tap_m_v;
    logic [WIDTH-1:0] tap_p_d;
    logic [WIDTH-1:0] tap_m_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        new_delay = cfg_delay;
        if (cfg_delay == '0)
            new_delay = DW'(1);
        else if (cfg_delay > DW'(MAX_DELAY))
            new_delay = DW'(MAX_DELAY);
        new_skew = cfg_skew;
        if (cfg_skew > SW'(MAX_SKEW))
            new_skew = SW'(MAX_SKEW);
    end

    // The complement is formed at capture, so a later mode change cannot alter words already in flight.
    always_comb begin
        if (!cur_mode)
            neg_word = ~in_data;
        else if (in_data == MOST_NEG)
            neg_word = ~MOST_NEG;
        else
            neg_word = -in_data;
    end

    // Stage i holds a word i cycles after its capture edge. Tap D-1 therefore feeds the output register at edge k+D.
    always_comb begin
        tap_p   = int'(cur_delay) - 1;
        tap_m   = int'(cur_delay) + int'(cur_skew) - 1;
        tap_p_v = 1'b0;
        tap_m_v = 1'b0;
        tap_p_d = '0;
        tap_m_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == tap_p) begin
                tap_p_v = pipe_v[i];
                tap_p_d = pipe_p[i];
            end
            if (i == tap_m) begin
                tap_m_v = pipe_v[i];
                tap_m_d = pipe_m[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every stage shifts off the same edge values.
    // NOTE: the data stages are reset too, so the pipeline holds no stale words after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_delay   <= DW'(1);
            cur_skew    <= '0;
            cur_mode    <= 1'b0;
            pipe_v      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pipe_p[i] <= '0;
                pipe_m[i] <= '0;
            end
            plus_valid  <= 1'b0;
            plus_data   <= '0;
            minus_valid <= 1'b0;
            minus_data  <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                pipe_p[i] <= pipe_p[i-1];
                pipe_m[i] <= pipe_m[i-1];
            end
            pipe_p[0] <= in_data;
            pipe_m[0] <= neg_word;
            if (cfg_load) begin
                cur_delay   <= new_delay;
                cur_skew    <= new_skew;
                cur_mode    <= cfg_mode;
                pipe_v      <= '0;
                plus_valid  <= 1'b0;
                plus_data   <= '0;
                minus_valid <= 1'b0;
                minus_data  <= '0;
            end else begin
                pipe_v      <= (pipe_v << 1) | DEPTH'(in_valid);
                plus_valid  <= tap_p_v;
                plus_data   <= tap_p_v ? tap_p_d : '0;
                minus_valid <= tap_m_v;
                minus_data  <= tap_m_v ? tap_m_d : '0;
            end
        end
    end

    assign busy = (|pipe_v) | plus_valid | minus_valid;

endmodule
